imem_loader: RTL and testbench

- Boot-time program loader upstream of the single-cycle processor core.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words sequentially into instruction memory from word address 0.
- Holds the core in reset until the requested number of words has been written, then releases it.

---
 rtl/imem_loader.sv | 212 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time program loader for the single-cycle core.
//                Collects a byte stream over a valid/ready handshake,
//                packs each group of four bytes into a big-endian 32-bit
//                instruction word and writes the words into instruction
//                memory sequentially from word address 0. The core is held
//                in reset until the requested number of words is written.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W        instruction-memory word-address width (DEPTH = 2**ADDR_W)
//  Ports
//    clk           system clock, rising-edge active
//    rst           asynchronous active-low reset
//    load_start    one-cycle load request (honoured in IDLE and DONE only)
//    load_len      number of words to load, sampled with load_start
//    byte_in       stream byte
//    byte_valid    byte_in is valid
//    byte_ready    loader accepts a byte this cycle
//    imem_we       instruction-memory write strobe, one cycle per word
//    imem_addr     word address of the write
//    imem_wdata    assembled instruction word
//    core_rst_n    active-low reset to the processor core
//    load_done     high while the loader is in DONE
//    err_len       sticky: last load_start requested more than DEPTH words
//    words_loaded  words written so far in the current load
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              err_len,
    output logic [ADDR_W:0]   words_loaded
);

    // DEPTH expressed at the width of load_len so the range check is exact.
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q,        state_d;
    logic [ADDR_W:0]     len_q,          len_d;
    logic [1:0]          idx_q,          idx_d;
    logic [31:0]         word_q,         word_d;
    logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
    logic                byte_ready_q,   byte_ready_d;
    logic                imem_we_q,      imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q,    imem_addr_d;
    logic [31:0]         imem_wdata_q,   imem_wdata_d;
    logic                core_rst_n_q,   core_rst_n_d;
    logic                load_done_q,    load_done_d;
    logic                err_len_q,      err_len_d;

    logic                w_accept;
    logic [31:0]         w_word_next;
    logic [ADDR_W:0]     w_words_inc;
    logic                w_len_zero;
    logic                w_len_bad;

    assign w_accept    = byte_valid && byte_ready_q && (state_q == S_RECV);
    assign w_words_inc = words_loaded_q + {{ADDR_W{1'b0}}, 1'b1};
    assign w_len_zero  = (load_len == '0);
    assign w_len_bad   = (load_len > DEPTH);

    // Insert the incoming byte at its big-endian lane: index 0 is the MSB.
    always_comb begin
        w_word_next = word_q;
        case (idx_q)
            2'd0:    w_word_next[31:24] = byte_in;
            2'd1:    w_word_next[23:16] = byte_in;
            2'd2:    w_word_next[15:8]  = byte_in;
            default: w_word_next[7:0]   = byte_in;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        idx_d          = idx_q;
        word_d         = word_q;
        words_loaded_d = words_loaded_q;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        err_len_d      = err_len_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    if (w_len_bad) begin
                        // Oversized request: flag it and park in IDLE.
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (w_len_zero) begin
                        // Empty program: nothing to write, release the core.
                        err_len_d      = 1'b0;
                        words_loaded_d = '0;
                        state_d        = S_DONE;
                    end else begin
                        len_d          = load_len;
                        words_loaded_d = '0;
                        idx_d          = 2'd0;
                        word_d         = '0;
                        err_len_d      = 1'b0;
                        state_d        = S_RECV;
                    end
                end
            end

            S_RECV: begin
                if (w_accept) begin
                    word_d = w_word_next;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Fourth byte: present the full word in the write cycle.
                        imem_addr_d  = words_loaded_q[ADDR_W-1:0];
                        imem_wdata_d = w_word_next;
                        state_d      = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                words_loaded_d = w_words_inc;
                idx_d          = 2'd0;
                if (w_words_inc == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RECV;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered, so each one is derived from the state being
    // entered. A load_start seen in DONE re-holds the core for at least one
    // cycle even when the new request leaves the loader in DONE.
    always_comb begin
        byte_ready_d = (state_d == S_RECV);
        imem_we_d    = (state_d == S_WRITE);
        load_done_d  = (state_d == S_DONE);
        core_rst_n_d = (state_d == S_DONE) && !((state_q == S_DONE) && load_start);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            idx_q          <= 2'd0;
            word_q         <= '0;
            words_loaded_q <= '0;
            byte_ready_q   <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            core_rst_n_q   <= 1'b0;
            load_done_q    <= 1'b0;
            err_len_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            word_q         <= word_d;
            words_loaded_q <= words_loaded_d;
            byte_ready_q   <= byte_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            core_rst_n_q   <= core_rst_n_d;
            load_done_q    <= load_done_d;
            err_len_q      <= err_len_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_rst_n   = core_rst_n_q;
    assign load_done    = load_done_q;
    assign err_len      = err_len_q;
    assign words_loaded = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader (ADDR_W = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              load_done;
    logic              err_len;
    logic [ADDR_W:0]   words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    // Write log filled by the monitor
    int          cyc  = 0;
    int          wr_n = 0;
    logic [7:0]  wr_addr [0:1023];
    logic [31:0] wr_data [0:1023];
    int          wr_cyc  [0:1023];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_len     (load_len),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst_n   (core_rst_n),
        .load_done    (load_done),
        .err_len      (err_len),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && imem_we && wr_n < 1024) begin
            wr_addr[wr_n] = imem_addr;
            wr_data[wr_n] = imem_wdata;
            wr_cyc[wr_n]  = cyc;
            wr_n          = wr_n + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All drive tasks start and end just after a rising edge.
    task automatic do_start(input logic [ADDR_W:0] len);
        load_start = 1'b1;
        load_len   = len;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done       = 1'b0;
        byte_valid = 1'b1;
        byte_in    = b;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (byte_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) check_eq("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (load_done) seen = 1'b1;
        end
        if (!seen) check_eq("load_done_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    int       base;
    int       done_cyc;
    logic [7:0] kb;

    initial begin
        rst        = 1'b0;
        load_start = 1'b0;
        load_len   = '0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;

        // ---------------- Reset values ----------------
        #3;
        check_eq("rst_byte_ready",   byte_ready,   0);
        check_eq("rst_imem_we",      imem_we,      0);
        check_eq("rst_imem_addr",    imem_addr,    0);
        check_eq("rst_imem_wdata",   imem_wdata,   0);
        check_eq("rst_core_rst_n",   core_rst_n,   0);
        check_eq("rst_load_done",    load_done,    0);
        check_eq("rst_err_len",      err_len,      0);
        check_eq("rst_words_loaded", words_loaded, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // ---------------- Length error in IDLE ----------------
        do_start(9'd257);
        @(negedge clk);
        check_eq("err_err_len",    err_len,    1);
        check_eq("err_byte_ready", byte_ready, 0);
        check_eq("err_core_rst_n", core_rst_n, 0);
        check_eq("err_load_done",  load_done,  0);
        repeat (2) @(posedge clk); #1;
        check_eq("err_still_idle", byte_ready, 0);

        // ---------------- Zero-length load ----------------
        do_start(9'd0);
        @(negedge clk);
        check_eq("zero_load_done",  load_done,  1);
        check_eq("zero_core_rst_n", core_rst_n, 1);
        check_eq("zero_err_len",    err_len,    0);
        @(posedge clk); #1;

        // ---------------- Reload from DONE, len=2, ignored starts ----------
        base = wr_n;
        do_start(9'd2);
        @(negedge clk);
        check_eq("reload_core_rst_n", core_rst_n, 0);
        check_eq("reload_load_done",  load_done,  0);
        check_eq("reload_byte_ready", byte_ready, 1);
        @(posedge clk); #1;
        send_byte(8'h01);
        send_byte(8'h02);
        byte_valid = 1'b0;
        do_start(9'd5);               // must be ignored in RECV
        send_byte(8'h03);
        send_byte(8'h04);
        byte_valid = 1'b0;
        do_start(9'd7);               // lands in WRITE or RECV; ignored
        send_word(32'hA0B1C2D3);
        byte_valid = 1'b0;
        wait_done(100);
        check_eq("reload_nwr",    wr_n - base, 2);
        check_eq("reload_addr0",  wr_addr[base],   8'h00);
        check_eq("reload_data0",  wr_data[base],   32'h01020304);
        check_eq("reload_addr1",  wr_addr[base+1], 8'h01);
        check_eq("reload_data1",  wr_data[base+1], 32'hA0B1C2D3);
        check_eq("reload_words",  words_loaded, 2);

        // ---------------- len=3 streaming ----------------
        base = wr_n;
        do_start(9'd3);
        send_word(32'h8C010004);
        send_word(32'h00221820);
        send_word(32'h08000000);
        byte_valid = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < 50 && done_cyc < 0; i++) begin
            @(negedge clk);
            if (load_done) done_cyc = cyc;
        end
        check_eq("s3_nwr",   wr_n - base, 3);
        check_eq("s3_data0", wr_data[base],   32'h8C010004);
        check_eq("s3_data1", wr_data[base+1], 32'h00221820);
        check_eq("s3_data2", wr_data[base+2], 32'h08000000);
        check_eq("s3_addr2", wr_addr[base+2], 8'h02);
        check_eq("s3_gap01", wr_cyc[base+1] - wr_cyc[base],   5);
        check_eq("s3_gap12", wr_cyc[base+2] - wr_cyc[base+1], 5);
        check_eq("s3_done_lat", done_cyc - wr_cyc[base+2], 1);
        check_eq("s3_core_rst_n", core_rst_n, 1);
        check_eq("s3_words", words_loaded, 3);
        @(posedge clk); #1;

        // ---------------- Stall pattern 1,0,0,1,... ----------------
        base = wr_n;
        do_start(9'd1);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: send_byte(8'hDE);
                1: send_byte(8'hAD);
                2: send_byte(8'hBE);
                default: send_byte(8'hEF);
            endcase
            byte_valid = 1'b0;
            byte_in    = 8'hFF;
            repeat (2) @(posedge clk); #1;
        end
        wait_done(20);
        check_eq("stall_nwr",  wr_n - base, 1);
        check_eq("stall_data", wr_data[base], 32'hDEADBEEF);
        check_eq("stall_addr", wr_addr[base], 8'h00);

        // ---------------- Reset mid-RECV ----------------
        do_start(9'd4);
        send_byte(8'hAA);
        send_byte(8'hBB);
        byte_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("abort_byte_ready", byte_ready,   0);
        check_eq("abort_imem_wdata", imem_wdata,   0);
        check_eq("abort_core_rst_n", core_rst_n,   0);
        check_eq("abort_load_done",  load_done,    0);
        check_eq("abort_words",      words_loaded, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        base = wr_n;
        do_start(9'd1);
        send_word(32'h11223344);
        byte_valid = 1'b0;
        wait_done(20);
        check_eq("post_nwr",  wr_n - base, 1);
        check_eq("post_data", wr_data[base], 32'h11223344);
        check_eq("post_addr", wr_addr[base], 8'h00);
        check_eq("post_done", load_done, 1);

        // ---------------- Full depth, len=256 ----------------
        base = wr_n;
        do_start(9'd256);
        for (int k = 0; k < 256; k++) begin
            kb = k[7:0];
            send_word({kb, ~kb, kb ^ 8'h55, 8'hA5});
        end
        byte_valid = 1'b0;
        wait_done(20);
        check_eq("full_nwr", wr_n - base, 256);
        for (int k = 0; k < 256; k++) begin
            kb = k[7:0];
            check_eq("full_addr", wr_addr[base+k], kb);
            check_eq("full_data", wr_data[base+k], {kb, ~kb, kb ^ 8'h55, 8'hA5});
        end
        check_eq("full_last_addr", wr_addr[base+255], 8'hFF);
        check_eq("full_words", words_loaded, 256);
        check_eq("full_done",  load_done, 1);
        check_eq("full_core",  core_rst_n, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
